// File: rtl/serial_id_reader.sv
// serial_id_reader: reads a DNA_PORT-style serial ID primitive through a divided id_clk.
// Define SERIAL_ID_DOUBLE_READ_EN to read the ID twice and publish it only when both reads agree.
module serial_id_reader #(
    parameter int ID_WIDTH  = 56,
    parameter int DIV       = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk26buf,
    input  logic                glbl_reset_n,
    input  logic                start,
    input  logic                id_dout,
    output logic                id_clk,
    output logic                id_read,
    output logic                id_shift,
    output logic [ID_WIDTH-1:0] id_data,
    output logic                id_valid,
    output logic                busy,
    output logic                id_mismatch
);
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(ID_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ID_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(ID_WIDTH - 2);

    typedef enum logic [3:0] {
        ST_INIT  = 4'b0001,
        ST_LOAD  = 4'b0010,
        ST_SHIFT = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    div_cnt;
    logic                tick;
    logic                dout_q;
    logic                start_pend;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                read_nxt, shift_nxt, busy_nxt;
    logic                sample, commit;
    logic [ID_WIDTH-1:0] shadow, shadow_nxt;

`ifdef SERIAL_ID_DOUBLE_READ_EN
    logic [ID_WIDTH-1:0] shadow_first;
    logic                second_pass, second_pass_nxt;
    logic                mismatch_nxt, first_end;
`endif

    function automatic logic [ID_WIDTH-1:0] shift_in(input logic [ID_WIDTH-1:0] cur,
                                                     input logic b);
        if (MSB_FIRST)
            return {cur[ID_WIDTH-2:0], b};
        else
            return {b, cur[ID_WIDTH-1:1]};
    endfunction

    assign tick       = (div_cnt == CNT_LAST);
    assign shadow_nxt = shift_in(shadow, dout_q);

    // Divider stage: id_clk high for the upper half of each period, falls on tick
    always_ff @(posedge clk26buf or negedge glbl_reset_n) begin
        if (!glbl_reset_n) begin
            div_cnt <= '0;
            id_clk  <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            id_clk  <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == CNT_RISE)
                id_clk <= 1'b1;
        end
    end

    // Capture id_dout just before id_clk rises, i.e. before the primitive advances
    always_ff @(posedge clk26buf) begin
        if (div_cnt == CNT_RISE)
            dout_q <= id_dout;
    end

    always_ff @(posedge clk26buf) begin
        if (sample)
            shadow <= shadow_nxt;
    end

`ifdef SERIAL_ID_DOUBLE_READ_EN
    always_ff @(posedge clk26buf) begin
        if (first_end)
            shadow_first <= shadow_nxt;
    end
`endif

    // FSM next-state stage
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        read_nxt    = id_read;
        shift_nxt   = id_shift;
        busy_nxt    = busy;
        sample      = 1'b0;
        commit      = 1'b0;
`ifdef SERIAL_ID_DOUBLE_READ_EN
        second_pass_nxt = second_pass;
        mismatch_nxt    = id_mismatch;
        first_end       = 1'b0;
`endif
        if (state == ST_INIT)
            busy_nxt = 1'b1;
        if (tick) begin
            unique case (state)
                ST_INIT: begin
                    state_nxt = ST_LOAD;
                    read_nxt  = 1'b1;
                end
                ST_LOAD: begin
                    state_nxt   = ST_SHIFT;
                    read_nxt    = 1'b0;
                    shift_nxt   = 1'b1;
                    bit_cnt_nxt = '0;
                end
                ST_SHIFT: begin
                    sample = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        shift_nxt = 1'b0;
`ifdef SERIAL_ID_DOUBLE_READ_EN
                        if (!second_pass) begin
                            state_nxt       = ST_LOAD;
                            read_nxt        = 1'b1;
                            second_pass_nxt = 1'b1;
                            first_end       = 1'b1;
                        end else begin
                            state_nxt       = ST_DONE;
                            busy_nxt        = 1'b0;
                            second_pass_nxt = 1'b0;
                            if (shadow_nxt == shadow_first) begin
                                commit       = 1'b1;
                                mismatch_nxt = 1'b0;
                            end else begin
                                mismatch_nxt = 1'b1;
                            end
                        end
`else
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        commit    = 1'b1;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        // Last bit is already on id_dout; no further shift edge needed
                        if (bit_cnt == BIT_STOP)
                            shift_nxt = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (start || start_pend) begin
                        state_nxt = ST_INIT;
                        busy_nxt  = 1'b1;
`ifdef SERIAL_ID_DOUBLE_READ_EN
                        mismatch_nxt    = 1'b0;
                        second_pass_nxt = 1'b0;
`endif
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    // Control and result register stage
    always_ff @(posedge clk26buf or negedge glbl_reset_n) begin
        if (!glbl_reset_n) begin
            state      <= ST_INIT;
            bit_cnt    <= '0;
            id_read    <= 1'b0;
            id_shift   <= 1'b0;
            busy       <= 1'b0;
            start_pend <= 1'b0;
            id_data    <= '0;
            id_valid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            id_read  <= read_nxt;
            id_shift <= shift_nxt;
            busy     <= busy_nxt;
            if (state == ST_DONE && !tick)
                start_pend <= start_pend | start;
            else
                start_pend <= 1'b0;
            if (commit) begin
                id_data  <= shadow_nxt;
                id_valid <= 1'b1;
            end
        end
    end

`ifdef SERIAL_ID_DOUBLE_READ_EN
    always_ff @(posedge clk26buf or negedge glbl_reset_n) begin
        if (!glbl_reset_n) begin
            second_pass <= 1'b0;
            id_mismatch <= 1'b0;
        end else begin
            second_pass <= second_pass_nxt;
            id_mismatch <= mismatch_nxt;
        end
    end
`else
    assign id_mismatch = 1'b0;
`endif

endmodule
